// File: rtl/mm_gpio_bank.sv
// GPIO bank on the MMPeripheral bus: LED/hex output registers, debounced switch/key inputs,
// edge-latched W1C status with a level IRQ, and a one-cycle registered read port.
module mm_gpio_bank #(
  parameter int unsigned GREEN_W         = 8,
  parameter int unsigned RED_W           = 10,
  parameter int unsigned SW_W            = 10,
  parameter int unsigned KEY_W           = 4,
  parameter int unsigned KEY_ACTIVE_LOW  = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ADDR_W          = 14
) (
  input  logic                CoreClock,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   AddressBus_P,
  input  logic [31:0]         DataWriteBus_P,
  input  logic                WriteAssert_P,
  input  logic                ReadAssert_P,
  output logic [31:0]         DataReadBus_P,
  output logic                ReadValid_P,
  output logic                Irq,
  output logic [GREEN_W-1:0]  w_LED_Green,
  output logic [RED_W-1:0]    W_LED_Red,
  output logic [15:0]         w_HexDisplay,
  input  logic [SW_W-1:0]     w_Switches,
  input  logic [KEY_W-1:0]    w_Keys
);

  localparam int unsigned N  = SW_W + KEY_W;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [KEY_W-1:0]   keysEff;
  logic [N-1:0]       rawIn, sync1, sync2, debounced, debPrev;
  logic [CW-1:0]      dbCount [N];
  logic [N-1:0]       rise, fall, w1cMask, statusNext;
  logic [N-1:0]       status, riseEn, fallEn;
  logic [GREEN_W-1:0] greenReg;
  logic [RED_W-1:0]   redReg;
  logic [15:0]        hexReg;
  logic [2:0]         offset;
  logic               hit, wrHit;
  logic [31:0]        readMux, readData;
  logic               readValid, irqReg;
  logic               unusedWriteBits;

  assign keysEff = (KEY_ACTIVE_LOW != 0) ? ~w_Keys : w_Keys;
  assign rawIn   = {keysEff, w_Switches};
  assign unusedWriteBits = ^DataWriteBus_P;

  // Synchroniser, per-bit debounce counter, and previous-value register for edge detect
  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      sync1     <= '0;
      sync2     <= '0;
      debounced <= '0;
      debPrev   <= '0;
      for (int unsigned i = 0; i < N; i++) dbCount[i] <= '0;
    end else begin
      sync1   <= rawIn;
      sync2   <= sync1;
      debPrev <= debounced;
      for (int unsigned i = 0; i < N; i++) begin
        if (sync2[i] == debounced[i]) begin
          dbCount[i] <= '0;
        end else if (dbCount[i] == CNT_LAST) begin
          debounced[i] <= sync2[i];
          dbCount[i]   <= '0;
        end else begin
          dbCount[i] <= dbCount[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    offset     = AddressBus_P[2:0];
    hit        = (AddressBus_P >> 3) == '0;
    wrHit      = WriteAssert_P & hit;
    rise       = debounced & ~debPrev;
    fall       = ~debounced & debPrev;
    w1cMask    = (wrHit && offset == 3'd4) ? DataWriteBus_P[N-1:0] : '0;
    // New edges are OR-ed in after the clear so a coincident set wins
    statusNext = (status & ~w1cMask) | (rise & riseEn) | (fall & fallEn);
  end

  always_comb begin
    readMux = '0;
    if (hit) begin
      case (offset)
        3'd0:    readMux = 32'(greenReg);
        3'd1:    readMux = 32'(redReg);
        3'd2:    readMux = 32'(hexReg);
        3'd3:    readMux = 32'(debounced);
        3'd4:    readMux = 32'(status);
        3'd5:    readMux = 32'(riseEn);
        3'd6:    readMux = 32'(fallEn);
        default: readMux = {8'hB1, 8'(N), 8'(RED_W), 8'(GREEN_W)};
      endcase
    end
  end

  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      greenReg  <= '0;
      redReg    <= '0;
      hexReg    <= '0;
      status    <= '0;
      riseEn    <= '0;
      fallEn    <= '0;
      irqReg    <= 1'b0;
      readValid <= 1'b0;
      readData  <= '0;
    end else begin
      status    <= statusNext;
      irqReg    <= |(status & (riseEn | fallEn));
      readValid <= ReadAssert_P;
      if (ReadAssert_P) readData <= readMux;
      if (wrHit) begin
        case (offset)
          3'd0:    greenReg <= DataWriteBus_P[GREEN_W-1:0];
          3'd1:    redReg   <= DataWriteBus_P[RED_W-1:0];
          3'd2:    hexReg   <= DataWriteBus_P[15:0];
          3'd5:    riseEn   <= DataWriteBus_P[N-1:0];
          3'd6:    fallEn   <= DataWriteBus_P[N-1:0];
          default: ;
        endcase
      end
    end
  end

  assign DataReadBus_P = readData;
  assign ReadValid_P   = readValid;
  assign Irq           = irqReg;
  assign w_LED_Green   = greenReg;
  assign W_LED_Red     = redReg;
  assign w_HexDisplay  = hexReg;

endmodule
